// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP encoding and PC step.
// State constants are plain localparams so legacy code can compare against them directly.
package riscv_pkg;

  typedef logic [2:0] fetch_state_e;

  localparam fetch_state_e S_IDLE = 3'd0;
  localparam fetch_state_e S_REQ  = 3'd1;
  localparam fetch_state_e S_WAIT = 3'd2;
  localparam fetch_state_e S_HOLD = 3'd3;
  localparam fetch_state_e S_KILL = 3'd4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: holds the fetch address, steps it by PC_STEP, and applies redirects.
// A redirect always wins over the sequential step.
module fetch_pc
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align_word(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM with a held output register for the decoder.
// Optional FETCH_PERF_CNT_EN adds o_fetch_cnt, counting accepted instruction words.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         vld_q, vld_d;
  logic         advance;
  logic         accept;
  logic [31:0]  pc;

  fetch_pc #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_fetch_pc (
    .clk           (i_clk),
    .rst_n         (i_rst_n),
    .redirect_i    (i_redirect),
    .redirect_pc_i (i_redirect_pc),
    .advance_i     (advance),
    .pc_o          (pc)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    advance = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (i_redirect) begin
          // Granted address is now stale; its response must be swallowed.
          state_d = i_imem_gnt ? S_KILL : S_REQ;
        end else if (i_imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_redirect) begin
          state_d = i_imem_rvalid ? S_REQ : S_KILL;
        end else if (i_imem_rvalid) begin
          inst_d  = i_imem_rdata;
          ipc_d   = pc;
          vld_d   = 1'b1;
          accept  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          vld_d   = 1'b0;
          state_d = S_REQ;
        end else if (i_inst_rdy) begin
          vld_d   = 1'b0;
          advance = 1'b1;
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        if (i_imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: only control and output-visible registers need a reset value; all of them here do.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      inst_q  <= NOP_INST;
      ipc_q   <= RESET_VECTOR;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
    end
  end

  assign o_imem_req  = (state_q == S_REQ);
  assign o_imem_addr = pc;
  assign o_inst      = inst_q;
  assign o_pc        = ipc_q;
  assign o_inst_vld  = vld_q;
  // Combinational pulse in the redirect cycle, forced low while reset is held.
  assign o_misalign  = i_rst_n & i_redirect & (|i_redirect_pc[1:0]);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= 32'd0;
    end else if (accept) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus hand-written
// sequences for asynchronous reset, stale responses and the optional fetch counter.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_inst_vld;
  logic        i_inst_rdy;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_fetch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_inst_vld    (o_inst_vld),
    .i_inst_rdy    (i_inst_rdy),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_misalign    (o_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt   (o_fetch_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    i_inst_rdy    = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
  endtask

  function automatic vec_t mk(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic rdy, input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc;
    v.e_mis = e_mis;
    return v;
  endfunction

  task automatic wait_req(input string name);
    for (int k = 0; k < 8 && !o_imem_req; k++) step();
    check({name, " req seen"}, {31'd0, o_imem_req}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data);
    wait_req("fetch");
    check("fetch addr", o_imem_addr, exp_pc);
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    step();
    i_imem_rvalid = 1'b0;
    check("fetch vld", {31'd0, o_inst_vld}, 32'd1);
    check("fetch inst", o_inst, data);
    check("fetch pc", o_pc, exp_pc);
    i_inst_rdy = 1'b1;
    step();
    i_inst_rdy = 1'b0;
  endtask

  initial begin
    // gnt rv rdata rdy redir rpc | req addr vld inst pc mis
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          0,32'h0,0,32'h13,32'h0,0));          // 0 IDLE
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h0,0,32'h13,32'h0,0));          // 1 REQ @0
    vecs.push_back(mk(0,1,32'hA000_0000,0,0,32'h0,  0,32'h0,0,32'h13,32'h0,0));          // 2 WAIT
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h0,1,32'hA000_0000,32'h0,0));   // 3 HOLD
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h4,0,32'hA000_0000,32'h0,0));   // 4 REQ @4
    vecs.push_back(mk(0,1,32'hA000_0004,0,0,32'h0,  0,32'h4,0,32'hA000_0000,32'h0,0));   // 5
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h4,1,32'hA000_0004,32'h4,0));   // 6
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h8,0,32'hA000_0004,32'h4,0));   // 7 gnt late
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h8,0,32'hA000_0004,32'h4,0));   // 8
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h8,0,32'hA000_0004,32'h4,0));   // 9
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          0,32'h8,0,32'hA000_0004,32'h4,0));   // 10 WAIT
    vecs.push_back(mk(0,1,32'hA000_0008,0,0,32'h0,  0,32'h8,0,32'hA000_0004,32'h4,0));   // 11
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          0,32'h8,1,32'hA000_0008,32'h8,0));   // 12 stall
    vecs.push_back(mk(0,1,32'hDEAD_BEEF,0,0,32'h0,  0,32'h8,1,32'hA000_0008,32'h8,0));   // 13 rv ignored
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h8,1,32'hA000_0008,32'h8,0));   // 14
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'hC,0,32'hA000_0008,32'h8,0));   // 15
    vecs.push_back(mk(0,0,32'h0,0,1,32'h100,        0,32'hC,0,32'hA000_0008,32'h8,0));   // 16 -> KILL
    vecs.push_back(mk(0,1,32'hBAD0_0000,0,0,32'h0,  0,32'h100,0,32'hA000_0008,32'h8,0)); // 17 stale
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h100,0,32'hA000_0008,32'h8,0)); // 18
    vecs.push_back(mk(0,1,32'hB000_0100,0,0,32'h0,  0,32'h100,0,32'hA000_0008,32'h8,0)); // 19
    vecs.push_back(mk(0,0,32'h0,0,1,32'h102,        0,32'h100,1,32'hB000_0100,32'h100,1)); // 20 misalign
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h100,0,32'hB000_0100,32'h100,0)); // 21
    vecs.push_back(mk(0,0,32'h0,0,1,32'h200,        1,32'h100,0,32'hB000_0100,32'h100,0)); // 22 redir no gnt
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h200,0,32'hB000_0100,32'h100,0)); // 23
    vecs.push_back(mk(0,1,32'hC000_0000,0,1,32'h300,0,32'h200,0,32'hB000_0100,32'h100,0)); // 24 discard
    vecs.push_back(mk(1,0,32'h0,0,1,32'h400,        1,32'h300,0,32'hB000_0100,32'h100,0)); // 25 -> KILL
    vecs.push_back(mk(0,0,32'h0,0,1,32'h501,        0,32'h400,0,32'hB000_0100,32'h100,1)); // 26 KILL redir
    vecs.push_back(mk(0,1,32'hBAD1_0000,0,0,32'h0,  0,32'h500,0,32'hB000_0100,32'h100,0)); // 27
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h500,0,32'hB000_0100,32'h100,0)); // 28
    vecs.push_back(mk(0,1,32'hD000_0000,0,0,32'h0,  0,32'h500,0,32'hB000_0100,32'h100,0)); // 29
    vecs.push_back(mk(0,0,32'h0,1,1,32'h600,        0,32'h500,1,32'hD000_0000,32'h500,0)); // 30 redir+rdy
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h600,0,32'hD000_0000,32'h500,0)); // 31
    vecs.push_back(mk(0,0,32'h0,0,1,32'hFFFF_FFFE,  1,32'h600,0,32'hD000_0000,32'h500,1)); // 32
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'hFFFF_FFFC,0,32'hD000_0000,32'h500,0)); // 33
    vecs.push_back(mk(0,1,32'hE000_0000,0,0,32'h0,  0,32'hFFFF_FFFC,0,32'hD000_0000,32'h500,0)); // 34
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'hFFFF_FFFC,1,32'hE000_0000,32'hFFFF_FFFC,0)); // 35
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h0,0,32'hE000_0000,32'hFFFF_FFFC,0)); // 36 wrap
    vecs.push_back(mk(0,0,32'h0,0,1,32'h700,        1,32'h0,0,32'hE000_0000,32'hFFFF_FFFC,0)); // 37
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          1,32'h700,0,32'hE000_0000,32'hFFFF_FFFC,0)); // 38

    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst req", {31'd0, o_imem_req}, 32'd0);
    check("rst vld", {31'd0, o_inst_vld}, 32'd0);
    check("rst inst", o_inst, 32'h0000_0013);
    check("rst pc", o_pc, RV);
    check("rst addr", o_imem_addr, RV);
    check("rst mis", {31'd0, o_misalign}, 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      i_imem_gnt    = vecs[i].gnt;
      i_imem_rvalid = vecs[i].rvalid;
      i_imem_rdata  = vecs[i].rdata;
      i_inst_rdy    = vecs[i].rdy;
      i_redirect    = vecs[i].redir;
      i_redirect_pc = vecs[i].rpc;
      @(negedge i_clk);
      check($sformatf("v%0d req", i),  {31'd0, o_imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d addr", i), o_imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d vld", i),  {31'd0, o_inst_vld}, {31'd0, vecs[i].e_vld});
      check($sformatf("v%0d inst", i), o_inst, vecs[i].e_inst);
      check($sformatf("v%0d pc", i),   o_pc, vecs[i].e_pc);
      check($sformatf("v%0d mis", i),  {31'd0, o_misalign}, {31'd0, vecs[i].e_mis});
      step();
    end

    // Now in S_WAIT at 0x700; reset asynchronously between edges.
    idle_inputs();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async rst addr", o_imem_addr, RV);
    check("async rst inst", o_inst, 32'h0000_0013);
    check("async rst pc", o_pc, RV);
    check("async rst req", {31'd0, o_imem_req}, 32'd0);
    step();
    i_rst_n = 1'b1;
    wait_req("post-reset");
    check("post-reset addr", o_imem_addr, RV);

    // Response with nothing outstanding is ignored.
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h5555_5555;
    step();
    i_imem_rvalid = 1'b0;
    check("stray rv inst", o_inst, 32'h0000_0013);
    check("stray rv vld", {31'd0, o_inst_vld}, 32'd0);
    check("stray rv req", {31'd0, o_imem_req}, 32'd1);

    // Killed response is neither latched nor counted.
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt    = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = RV;
    step();
    i_redirect    = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h6666_6666;
    step();
    i_imem_rvalid = 1'b0;
    check("kill inst", o_inst, 32'h0000_0013);

    for (int n = 0; n < 5; n++) begin
      do_fetch(RV + 32'(4 * n), 32'h7000_0000 + 32'(n));
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch cnt", o_fetch_cnt, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
